lcd_cmd_arbiter: RTL and testbench
==================================

// Module: lcd_cmd_arbiter
// PURPOSE
//   Shares one LCD display controller (6x6 image, 3x3 window, 3-bit cmd) between two requesters.
//   Round-robin grants, one command in flight at a time. Streams the 36-pixel image from the
//   granted requester's sync-read buffer on Load. Tracks the 9-pixel window readout and pulses done.
// PARAMETERS
//   NUM_PIX  36  pixels streamed per Load command
//   WIN_PIX  9   window pixels (lcd_output_valid beats) expected per command
//   TIMEOUT  64  watchdog limit in cycles (used only with LCD_ARB_WDOG_EN)
// PORTS
//   clk               in   1  single clock, rising edge
//   reset             in   1  synchronous, active-high
//   rq0_req/rq1_req   in   1  request pending; held until gnt
//   rq0_cmd/rq1_cmd   in   3  0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down
//   rq0_gnt/rq1_gnt   out  1  one-cycle pulse: command accepted
//   rq0_done/rq1_done out  1  one-cycle pulse: command finished (or rejected)
//   rd_addr           out  6  pixel index to granted requester's buffer
//   rd_data0/rd_data1 in   8  buffer data, valid 1 cycle after rd_addr
//   lcd_cmd           out  3  command to LCD controller
//   lcd_cmd_valid     out  1  one-cycle command strobe
//   lcd_datain        out  8  pixel stream to LCD controller
//   lcd_busy          in   1  LCD busy (combinational on LCD side)
//   lcd_output_valid  in   1  LCD window-pixel strobe
//   cmd_err           out  1  one-cycle pulse: illegal cmd (6,7) rejected
//   wdog_err          out  1  sticky watchdog flag (0 when macro off)
// BEHAVIOUR
//   - Reset: state IDLE. gnt, done, lcd_cmd_valid, cmd_err, wdog_err = 0. lcd_cmd = 0, rd_addr = 0.
//     RR pointer favours rq0. Pixel/beat counters = 0. Reset mid-command aborts immediately.
//     No drain is performed. The LCD is reset by the same reset.
//   - FSM states: IDLE -> ISSUE -> (STREAM if Load) -> WAIT -> IDLE.
//   - IDLE: arbitrates only when some req=1 and lcd_busy=0.
//     - Both requesting: grant the one not granted last; pointer flips on every grant.
//     - Latch sel and cmd. Go to ISSUE next cycle.
//   - ISSUE (1 cycle): gnt of sel = 1.
//     - Legal cmd: lcd_cmd_valid = 1, lcd_cmd = latched cmd.
//       Load -> rd_addr <= 0, go STREAM. Others -> go WAIT.
//     - Cmd 6/7: not forwarded. cmd_err + done pulse next cycle, back to IDLE.
//   - lcd_datain = rd_data[sel] combinationally, at all times.
//   - STREAM: rd_addr increments 0..NUM_PIX-1, one per cycle from ISSUE.
//     - Pixel k appears on lcd_datain exactly 1+k cycles after the lcd_cmd_valid cycle.
//     - Leaves for WAIT after pixel NUM_PIX-1 has been presented (NUM_PIX cycles).
//     - rd_addr holds NUM_PIX-1 afterwards. No overrun, no wrap.
//   - WAIT: counts lcd_output_valid beats, saturating at WIN_PIX.
//     - Exit when count == WIN_PIX and lcd_busy = 0.
//     - On exit: done of sel = 1 for one cycle, clear count, go IDLE.
//   - New requests during ISSUE/STREAM/WAIT: not granted until IDLE; requesters keep req held.
//   - req dropped before gnt: withdrawn, no gnt/done. req dropped after gnt: no effect.
//   - Back-to-back: next grant is no earlier than the cycle after done.
//   - lcd_cmd_valid is never asserted while lcd_busy = 1 was sampled in IDLE.
// CONFIGURATION
//   LCD_ARB_WDOG_EN defined:
//     - Cycle counter runs in STREAM+WAIT. Reaching TIMEOUT forces IDLE.
//     - Sets sticky wdog_err (cleared only by reset). Pulses done of sel.
//   LCD_ARB_WDOG_EN undefined:
//     - No counter. wdog_err tied 0. WAIT waits indefinitely.
// TESTING
//   1. rq0 Load, buffer[k]=k+1 -> gnt0 1 cycle after req; lcd_datain = 1..36 on 36 cycles
//      after lcd_cmd_valid; done0 after 9 output_valid beats.
//   2. rq0 and rq1 both Right, same cycle after reset -> rq0 granted first, rq1 second;
//      two lcd_cmd_valid pulses with cmd=2, separated until done0.
//   3. rq1 held, rq0 re-requests 3x -> grants alternate 0,1,0,1; no requester starved.
//   4. rq0 cmd=7 -> gnt0, cmd_err and done0 pulse; lcd_cmd_valid stays 0.
//   5. Reset asserted at pixel 20 of Load -> next cycle all outputs 0, state IDLE;
//      new Load restarts at rd_addr 0.
//   6. WDOG_EN, TIMEOUT=64, LCD model never drops busy -> wdog_err=1 and done0 after 64
//      cycles; without macro, done0 never asserts.

Source files
------------

// File: rtl/lcd_cmd_arbiter.sv
// Round-robin arbiter sharing one LCD controller between two requesters; streams Load images.
// Optional watchdog over STREAM/WAIT is enabled by defining LCD_ARB_WDOG_EN.
module lcd_cmd_arbiter #(
  parameter int unsigned NUM_PIX = 36,
  parameter int unsigned WIN_PIX = 9,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rq0_req,
  input  logic [2:0] rq0_cmd,
  output logic       rq0_gnt,
  output logic       rq0_done,
  input  logic       rq1_req,
  input  logic [2:0] rq1_cmd,
  output logic       rq1_gnt,
  output logic       rq1_done,
  output logic [5:0] rd_addr,
  input  logic [7:0] rd_data0,
  input  logic [7:0] rd_data1,
  output logic [2:0] lcd_cmd,
  output logic       lcd_cmd_valid,
  output logic [7:0] lcd_datain,
  input  logic       lcd_busy,
  input  logic       lcd_output_valid,
  output logic       cmd_err,
  output logic       wdog_err
);

  localparam int unsigned BW        = $clog2(WIN_PIX + 1);
  localparam logic [5:0]  LAST_ADDR = 6'(NUM_PIX - 1);
  localparam logic [BW-1:0] BEAT_MAX = BW'(WIN_PIX);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_STREAM, S_WAIT} state_t;

  state_t        state, state_nxt;
  logic          sel, last_sel, arb_sel;
  logic [2:0]    cmd_q;
  logic [5:0]    pix_cnt;
  logic [BW-1:0] beat_cnt;
  logic [1:0]    done_q;
  logic [1:0]    gnt_c;
  logic          grant, cmd_legal, is_load, stream_last, wait_exit, wd_hit;

  assign grant       = (state == S_IDLE) && (rq0_req || rq1_req) && !lcd_busy;
  assign cmd_legal   = (cmd_q <= 3'd5);
  assign is_load     = (cmd_q == 3'd1);
  assign stream_last = (pix_cnt == LAST_ADDR);
  assign wait_exit   = (beat_cnt == BEAT_MAX) && !lcd_busy;
  assign lcd_datain  = sel ? rd_data1 : rd_data0;
  assign rq0_done    = done_q[0];
  assign rq1_done    = done_q[1];
  assign rq0_gnt     = gnt_c[0];
  assign rq1_gnt     = gnt_c[1];

  // With both pending, favour the one not granted last; otherwise the sole requester.
  always_comb begin
    arb_sel = rq1_req;
    if (rq0_req && rq1_req) arb_sel = ~last_sel;
  end

`ifdef LCD_ARB_WDOG_EN
  localparam int unsigned WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd_cnt;
  logic          wdog_q;

  assign wd_hit   = ((state == S_STREAM) || (state == S_WAIT)) && (wd_cnt == WW'(TIMEOUT - 1));
  assign wdog_err = wdog_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_cnt <= '0;
      wdog_q <= 1'b0;
    end else begin
      if (((state == S_STREAM) || (state == S_WAIT)) && !wd_hit) wd_cnt <= wd_cnt + WW'(1);
      else                                                      wd_cnt <= '0;
      if (wd_hit) wdog_q <= 1'b1;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign wd_hit   = 1'b0;
  assign wdog_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (grant) state_nxt = S_ISSUE;
      S_ISSUE:  begin
        if (!cmd_legal)   state_nxt = S_IDLE;
        else if (is_load) state_nxt = S_STREAM;
        else              state_nxt = S_WAIT;
      end
      S_STREAM: if (stream_last) state_nxt = S_WAIT;
      S_WAIT:   if (wait_exit)   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
    if (wd_hit) state_nxt = S_IDLE;
  end

  always_comb begin
    gnt_c         = '0;
    lcd_cmd_valid = 1'b0;
    lcd_cmd       = '0;
    if (state == S_ISSUE) begin
      gnt_c[sel]    = 1'b1;
      lcd_cmd_valid = cmd_legal;
      if (cmd_legal) lcd_cmd = cmd_q;
    end
  end

  // rd_addr is 0 during ISSUE so pixel 0 lands on lcd_datain the cycle after the strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel      <= 1'b0;
      last_sel <= 1'b1;
      cmd_q    <= '0;
      rd_addr  <= '0;
      pix_cnt  <= '0;
      beat_cnt <= '0;
      done_q   <= '0;
      cmd_err  <= 1'b0;
    end else begin
      done_q  <= '0;
      cmd_err <= 1'b0;
      case (state)
        S_IDLE: if (grant) begin
          sel      <= arb_sel;
          last_sel <= arb_sel;
          cmd_q    <= arb_sel ? rq1_cmd : rq0_cmd;
          rd_addr  <= '0;
          pix_cnt  <= '0;
          beat_cnt <= '0;
        end
        S_ISSUE: begin
          if (!cmd_legal) begin
            cmd_err     <= 1'b1;
            done_q[sel] <= 1'b1;
          end else if (is_load && (rd_addr != LAST_ADDR)) begin
            rd_addr <= rd_addr + 6'd1;
          end
        end
        S_STREAM: begin
          if (rd_addr != LAST_ADDR) rd_addr <= rd_addr + 6'd1;
          if (!stream_last)         pix_cnt <= pix_cnt + 6'd1;
        end
        S_WAIT: begin
          if (lcd_output_valid && (beat_cnt != BEAT_MAX)) beat_cnt <= beat_cnt + BW'(1);
          if (wait_exit) begin
            done_q[sel] <= 1'b1;
            beat_cnt    <= '0;
          end
        end
        default: ;
      endcase
      if (wd_hit) begin
        done_q[sel] <= 1'b1;
        beat_cnt    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lcd_cmd_arbiter.sv
// Directed self-checking bench for lcd_cmd_arbiter; buffers hold k+1 (rq0) and k+101 (rq1).
// Watchdog expectations follow LCD_ARB_WDOG_EN.
module tb_lcd_cmd_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rq0_req = 1'b0, rq1_req = 1'b0;
  logic [2:0] rq0_cmd = '0, rq1_cmd = '0;
  logic       rq0_gnt, rq1_gnt, rq0_done, rq1_done;
  logic [5:0] rd_addr;
  logic [7:0] rd_data0 = '0, rd_data1 = '0;
  logic [2:0] lcd_cmd;
  logic       lcd_cmd_valid;
  logic [7:0] lcd_datain;
  logic       lcd_busy = 1'b0, lcd_output_valid = 1'b0;
  logic       cmd_err, wdog_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    rd_data0 <= 8'(rd_addr) + 8'd1;
    rd_data1 <= 8'(rd_addr) + 8'd101;
  end

  lcd_cmd_arbiter #(.NUM_PIX(36), .WIN_PIX(9), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .rq0_req(rq0_req), .rq0_cmd(rq0_cmd), .rq0_gnt(rq0_gnt), .rq0_done(rq0_done),
    .rq1_req(rq1_req), .rq1_cmd(rq1_cmd), .rq1_gnt(rq1_gnt), .rq1_done(rq1_done),
    .rd_addr(rd_addr), .rd_data0(rd_data0), .rd_data1(rd_data1),
    .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid), .lcd_datain(lcd_datain),
    .lcd_busy(lcd_busy), .lcd_output_valid(lcd_output_valid),
    .cmd_err(cmd_err), .wdog_err(wdog_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_beats(input int n);
    for (int i = 0; i < n; i++) begin
      lcd_output_valid = 1'b1;
      tick();
    end
    lcd_output_valid = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    rq0_req = 1'b0; rq1_req = 1'b0;
    lcd_busy = 1'b0; lcd_output_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    tests++;
    if ({rq0_gnt, rq1_gnt, rq0_done, rq1_done, lcd_cmd_valid, cmd_err, wdog_err} !== 7'b0) begin
      fails++;
      $display("FAIL reset_pulses: got %b expected 0000000",
               {rq0_gnt, rq1_gnt, rq0_done, rq1_done, lcd_cmd_valid, cmd_err, wdog_err});
    end
    tests++;
    if (lcd_cmd !== 3'd0 || rd_addr !== 6'd0) begin
      fails++;
      $display("FAIL reset_regs: got cmd=%0d addr=%0d expected 0/0", lcd_cmd, rd_addr);
    end
  endtask

  task automatic test_load();
    bit bad_pix = 1'b0;
    bit stray   = 1'b0;
    rq0_req = 1'b1; rq0_cmd = 3'd1;
    tick();
    tests++;
    if (rq0_gnt !== 1'b1 || rq1_gnt !== 1'b0 || lcd_cmd_valid !== 1'b1 || lcd_cmd !== 3'd1) begin
      fails++;
      $display("FAIL load_issue: got gnt0=%b gnt1=%b v=%b cmd=%0d expected 1 0 1 1",
               rq0_gnt, rq1_gnt, lcd_cmd_valid, lcd_cmd);
    end
    rq0_req = 1'b0;
    for (int k = 0; k < 36; k++) begin
      tick();
      if (lcd_datain !== 8'(k + 1)) begin
        if (!bad_pix) $display("FAIL load_pixel: k=%0d got %0d expected %0d", k, lcd_datain, k + 1);
        bad_pix = 1'b1;
      end
      if (lcd_cmd_valid || rq0_gnt || rq1_gnt || rq0_done) stray = 1'b1;
    end
    tests++;
    if (bad_pix) fails++;
    tests++;
    if (stray) begin
      fails++;
      $display("FAIL load_stray: got stray strobe during stream expected none");
    end
    tick();
    tests++;
    if (rd_addr !== 6'd35) begin
      fails++;
      $display("FAIL load_addr_hold: got %0d expected 35", rd_addr);
    end
    run_beats(8);
    tests++;
    if (rq0_done !== 1'b0) begin
      fails++;
      $display("FAIL load_early_done: got %b expected 0", rq0_done);
    end
    run_beats(1);
    tick();
    tests++;
    if (rq0_done !== 1'b1 || rq1_done !== 1'b0) begin
      fails++;
      $display("FAIL load_done: got done0=%b done1=%b expected 1 0", rq0_done, rq1_done);
    end
    tick();
    tests++;
    if (rq0_done !== 1'b0) begin
      fails++;
      $display("FAIL load_done_pulse: got %b expected 0", rq0_done);
    end
  endtask

  task automatic test_both_right();
    bit early = 1'b0;
    apply_reset();
    rq0_req = 1'b1; rq0_cmd = 3'd2;
    rq1_req = 1'b1; rq1_cmd = 3'd2;
    tick();
    tests++;
    if (rq0_gnt !== 1'b1 || rq1_gnt !== 1'b0 || lcd_cmd_valid !== 1'b1 || lcd_cmd !== 3'd2) begin
      fails++;
      $display("FAIL both_first: got gnt0=%b gnt1=%b v=%b cmd=%0d expected 1 0 1 2",
               rq0_gnt, rq1_gnt, lcd_cmd_valid, lcd_cmd);
    end
    rq0_req = 1'b0;
    tick();
    for (int i = 0; i < 9; i++) begin
      lcd_output_valid = 1'b1;
      tick();
      if (rq1_gnt || lcd_cmd_valid) early = 1'b1;
    end
    lcd_output_valid = 1'b0;
    tick();
    tests++;
    if (rq0_done !== 1'b1 || rq1_gnt !== 1'b0 || early) begin
      fails++;
      $display("FAIL both_done0: got done0=%b gnt1=%b early=%b expected 1 0 0", rq0_done, rq1_gnt, early);
    end
    tick();
    tests++;
    if (rq1_gnt !== 1'b1 || lcd_cmd_valid !== 1'b1 || lcd_cmd !== 3'd2) begin
      fails++;
      $display("FAIL both_second: got gnt1=%b v=%b cmd=%0d expected 1 1 2", rq1_gnt, lcd_cmd_valid, lcd_cmd);
    end
    rq1_req = 1'b0;
    tick();
    run_beats(9);
    tick();
    tests++;
    if (rq1_done !== 1'b1 || rq0_done !== 1'b0) begin
      fails++;
      $display("FAIL both_done1: got done1=%b done0=%b expected 1 0", rq1_done, rq0_done);
    end
    tick();
  endtask

  task automatic test_round_robin();
    rq0_req = 1'b1; rq0_cmd = 3'd3;
    rq1_req = 1'b1; rq1_cmd = 3'd3;
    for (int g = 0; g < 4; g++) begin
      int n = 0;
      bit exp1 = (g % 2) == 1;
      while (!(rq0_gnt || rq1_gnt) && n < 20) begin
        tick();
        n++;
      end
      tests++;
      if ({rq1_gnt, rq0_gnt} !== (exp1 ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_grant%0d: got gnt1,gnt0=%b%b expected %s", g, rq1_gnt, rq0_gnt, exp1 ? "10" : "01");
      end
      if (g == 3) begin
        rq0_req = 1'b0;
        rq1_req = 1'b0;
      end
      tick();
      run_beats(9);
      tick();
      tests++;
      if ({rq1_done, rq0_done} !== (exp1 ? 2'b10 : 2'b01)) begin
        fails++;
        $display("FAIL rr_done%0d: got done1,done0=%b%b expected %s", g, rq1_done, rq0_done, exp1 ? "10" : "01");
      end
    end
    tick();
  endtask

  task automatic test_illegal();
    rq0_req = 1'b1; rq0_cmd = 3'd7;
    tick();
    tests++;
    if (rq0_gnt !== 1'b1 || lcd_cmd_valid !== 1'b0 || lcd_cmd !== 3'd0 || cmd_err !== 1'b0) begin
      fails++;
      $display("FAIL illegal_issue: got gnt0=%b v=%b cmd=%0d err=%b expected 1 0 0 0",
               rq0_gnt, lcd_cmd_valid, lcd_cmd, cmd_err);
    end
    rq0_req = 1'b0;
    tick();
    tests++;
    if (cmd_err !== 1'b1 || rq0_done !== 1'b1 || rq1_done !== 1'b0 || lcd_cmd_valid !== 1'b0) begin
      fails++;
      $display("FAIL illegal_err: got err=%b done0=%b done1=%b v=%b expected 1 1 0 0",
               cmd_err, rq0_done, rq1_done, lcd_cmd_valid);
    end
    tick();
    tests++;
    if (cmd_err !== 1'b0 || rq0_done !== 1'b0) begin
      fails++;
      $display("FAIL illegal_pulse: got err=%b done0=%b expected 0 0", cmd_err, rq0_done);
    end
    rq1_req = 1'b1; rq1_cmd = 3'd6;
    tick();
    rq1_req = 1'b0;
    tick();
    tests++;
    if (cmd_err !== 1'b1 || rq1_done !== 1'b1 || rq0_done !== 1'b0) begin
      fails++;
      $display("FAIL illegal_rq1: got err=%b done1=%b done0=%b expected 1 1 0", cmd_err, rq1_done, rq0_done);
    end
    tick();
  endtask

  task automatic test_busy_gating();
    bit stray = 1'b0;
    lcd_busy = 1'b1;
    rq0_req = 1'b1; rq0_cmd = 3'd0;
    tick();
    tick();
    rq0_req = 1'b0;
    lcd_busy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rq0_gnt || rq1_gnt || lcd_cmd_valid) stray = 1'b1;
    end
    tests++;
    if (stray) begin
      fails++;
      $display("FAIL withdraw: got grant after req dropped expected none");
    end
    stray = 1'b0;
    lcd_busy = 1'b1;
    rq1_req = 1'b1; rq1_cmd = 3'd4;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (rq0_gnt || rq1_gnt || lcd_cmd_valid) stray = 1'b1;
    end
    tests++;
    if (stray) begin
      fails++;
      $display("FAIL busy_block: got grant while busy expected none");
    end
    lcd_busy = 1'b0;
    tick();
    tests++;
    if (rq1_gnt !== 1'b1 || lcd_cmd !== 3'd4 || lcd_cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL busy_grant: got gnt1=%b cmd=%0d v=%b expected 1 4 1", rq1_gnt, lcd_cmd, lcd_cmd_valid);
    end
    rq1_req = 1'b0;
    tick();
    lcd_busy = 1'b1;
    run_beats(12);
    tick();
    tests++;
    if (rq1_done !== 1'b0) begin
      fails++;
      $display("FAIL busy_hold_done: got %b expected 0", rq1_done);
    end
    lcd_busy = 1'b0;
    tick();
    tests++;
    if (rq1_done !== 1'b1) begin
      fails++;
      $display("FAIL busy_release_done: got %b expected 1", rq1_done);
    end
    tick();
  endtask

  task automatic test_reset_mid_load();
    apply_reset();
    rq0_req = 1'b1; rq0_cmd = 3'd1;
    tick();
    rq0_req = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    tests++;
    if (lcd_datain !== 8'd20) begin
      fails++;
      $display("FAIL midreset_pre: got %0d expected 20", lcd_datain);
    end
    reset = 1'b1;
    tick();
    tests++;
    if ({rq0_gnt, rq1_gnt, rq0_done, rq1_done, lcd_cmd_valid, cmd_err} !== 6'b0 ||
        rd_addr !== 6'd0 || lcd_cmd !== 3'd0) begin
      fails++;
      $display("FAIL midreset_outputs: got pulses=%b addr=%0d cmd=%0d expected 0 0 0",
               {rq0_gnt, rq1_gnt, rq0_done, rq1_done, lcd_cmd_valid, cmd_err}, rd_addr, lcd_cmd);
    end
    reset = 1'b0;
    rq0_req = 1'b1;
    tick();
    tests++;
    if (rq0_gnt !== 1'b1 || rd_addr !== 6'd0 || lcd_cmd_valid !== 1'b1) begin
      fails++;
      $display("FAIL midreset_regrant: got gnt0=%b addr=%0d v=%b expected 1 0 1", rq0_gnt, rd_addr, lcd_cmd_valid);
    end
    rq0_req = 1'b0;
    tick();
    tests++;
    if (lcd_datain !== 8'd1 || rd_addr !== 6'd1) begin
      fails++;
      $display("FAIL midreset_restart: got data=%0d addr=%0d expected 1 1", lcd_datain, rd_addr);
    end
    apply_reset();
  endtask

  task automatic test_watchdog();
    int n = 0;
    rq0_req = 1'b1; rq0_cmd = 3'd2;
    tick();
    rq0_req = 1'b0;
    lcd_busy = 1'b1;
    while (!rq0_done && n < 100) begin
      tick();
      n++;
    end
`ifdef LCD_ARB_WDOG_EN
    tests++;
    if (rq0_done !== 1'b1 || n != 65 || wdog_err !== 1'b1) begin
      fails++;
      $display("FAIL wdog_fire: got done0=%b after %0d cycles err=%b expected 1 after 65 err=1", rq0_done, n, wdog_err);
    end
    tick();
    tick();
    tests++;
    if (wdog_err !== 1'b1 || rq0_done !== 1'b0) begin
      fails++;
      $display("FAIL wdog_sticky: got err=%b done0=%b expected 1 0", wdog_err, rq0_done);
    end
`else
    tests++;
    if (rq0_done !== 1'b0 || wdog_err !== 1'b0) begin
      fails++;
      $display("FAIL wdog_off: got done0=%b err=%b after %0d cycles expected 0 0", rq0_done, wdog_err, n);
    end
`endif
    apply_reset();
    tests++;
    if (wdog_err !== 1'b0) begin
      fails++;
      $display("FAIL wdog_clear: got %b expected 0", wdog_err);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_both_right();
    test_round_robin();
    test_illegal();
    test_busy_gating();
    test_reset_mid_load();
    test_watchdog();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
